// File: rtl/instr_encoder_pkg.sv
// Shared opcode, format-group and FSM definitions for the RV32I instruction encoder.
// Format groups mirror the main decoder's IG_* set so both sides agree on opcode classes.
package instr_encoder_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IG_NONE,
        IG_R,
        IG_I,
        IG_S,
        IG_B,
        IG_U,
        IG_J
    } ig_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    function automatic ig_t opcode_to_ig(input logic [6:0] op);
        case (op)
            OP_OP:                        return IG_R;
            OP_OP_IMM, OP_LOAD, OP_JALR:  return IG_I;
            OP_STORE:                     return IG_S;
            OP_BRANCH:                    return IG_B;
            OP_LUI, OP_AUIPC:             return IG_U;
            OP_JAL:                       return IG_J;
            default:                      return IG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational opcode-to-format select and RV32I field packing (instr_pack).
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        ok
);

    ig_t fmt;

    always_comb begin
        fmt  = opcode_to_ig(f.opcode);
        word = '0;
        ok   = 1'b1;
        case (fmt)
            IG_R: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            IG_I: word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            IG_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            IG_B: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:1], f.imm[11], f.opcode};
            IG_U: word = {f.imm[31:12], f.rd, f.opcode};
            IG_J: word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: ok = 1'b0;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // Signed fit: every bit above the format's sign bit must replicate it.
        case (fmt)
            IG_I, IG_S: if (f.imm[31:11] != {21{f.imm[11]}}) ok = 1'b0;
            IG_B:       if ((f.imm[31:12] != {20{f.imm[12]}}) || f.imm[0]) ok = 1'b0;
            IG_J:       if ((f.imm[31:20] != {12{f.imm[20]}}) || f.imm[0]) ok = 1'b0;
            IG_U:       if (f.imm[11:0] != '0) ok = 1'b0;
            default:    ;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / IMEM program loader: FSM, one-entry output buffer, counters.
// Define IMM_RANGE_CHECK_EN to reject immediates that do not fit their format.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              err,
    output logic              full
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t      state, state_nxt;
    logic        buf_v;
    logic        accept, wr_done, hit_depth;
    logic [31:0] pack_word;
    logic        pack_ok;
    fields_t     fields;

    always_comb begin
        fields        = '0;
        fields.opcode = in_opcode;
        fields.funct3 = in_funct3;
        fields.funct7 = in_funct7;
        fields.rd     = in_rd;
        fields.rs1    = in_rs1;
        fields.rs2    = in_rs2;
        fields.imm    = in_imm;
    end

    instr_pack u_pack (
        .f    (fields),
        .word (pack_word),
        .ok   (pack_ok)
    );

    assign full = (state == ST_FULL);

    // A word still buffered when FULL is reached is held back and later dropped by start.
    always_comb begin
        state_nxt = state;
        imem_we   = buf_v && (state == ST_RUN);
        in_ready  = (state == ST_RUN) && !full && (!buf_v || imem_ready);
        wr_done   = imem_we && imem_ready;
        accept    = in_valid && in_ready && !start;
        hit_depth = wr_done && (wr_cnt == LAST_CNT);
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (start)          state_nxt = ST_RUN;
                else if (hit_depth) state_nxt = ST_FULL;
            end
            ST_FULL: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            buf_v      <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            wr_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept && !pack_ok;
            if (start) begin
                buf_v     <= 1'b0;
                imem_addr <= base_addr;
                wr_cnt    <= '0;
            end else begin
                if (wr_done) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                    wr_cnt    <= wr_cnt + (ADDR_W+1)'(1);
                end
                if (accept && pack_ok) begin
                    buf_v      <= 1'b1;
                    imem_wdata <= pack_word;
                end else if (wr_done) begin
                    buf_v <= 1'b0;
                end
            end
        end
    end

endmodule
